// File: rtl/shuffle_pkg.sv
// Shared constants, types and helpers for the 3-parallel delay-commutator shuffler.
package shuffle_pkg;

  localparam int DATA_W = 32;
  localparam int NLANES = 3;
  localparam int RE_LSB = 16;

  // Packed lane layout: real part in the upper half, imaginary part in the lower half.
  typedef struct packed {
    logic signed [DATA_W-RE_LSB-1:0] re;
    logic signed [RE_LSB-1:0]        im;
  } cplx_t;

  typedef enum logic [1:0] {
    SEG0 = 2'd0,
    SEG1 = 2'd1,
    SEG2 = 2'd2
  } seg_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Delayed input lane routed to switch output k for rotation r.
  function automatic logic [1:0] src_lane(input seg_e r, input int unsigned k);
    int unsigned s;
    s = (32'(r) + 32'd3 - k) % 32'd3;
    return 2'(s);
  endfunction

endpackage

// File: rtl/dly_line.sv
// Enabled shift-register delay of DEPTH samples on the falling clock edge.
module dly_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, en};
    assign q = d;
  end else begin : g_sr
    logic [DATA_W-1:0] sr_q [DEPTH];

    // NOTE: this storage is cleared on reset so stale samples never reach the output.
    always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else if (en) begin
        sr_q[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
    end

    assign q = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/shuffle3_dc.sv
// 3-parallel delay commutator: transposes D-sample segments against the three lanes.
module shuffle3_dc
  import shuffle_pkg::*;
#(
  parameter int D      = 3,
  parameter int DATA_W = shuffle_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] x0,
  input  logic [DATA_W-1:0] x1,
  input  logic [DATA_W-1:0] x2,
  output logic              out_valid,
  output logic [DATA_W-1:0] y0,
  output logic [DATA_W-1:0] y1,
  output logic [DATA_W-1:0] y2,
  output logic              frame_start
);

  localparam int OFF_W = cnt_w(D);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(D - 1);

  logic [DATA_W-1:0] x_in  [NLANES];
  logic [DATA_W-1:0] x_dly [NLANES];
  logic [DATA_W-1:0] sw    [NLANES];
  logic [DATA_W-1:0] y_pre [NLANES];
  logic [DATA_W-1:0] y_q   [NLANES];

  logic [OFF_W-1:0] off_q, off_d;
  seg_e             seg_q, seg_d;
  logic             primed_q, primed_d;
  logic             valid_q, fs_q;

  assign x_in[0] = x0;
  assign x_in[1] = x1;
  assign x_in[2] = x2;

  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    dly_line #(.DEPTH(k * D), .DATA_W(DATA_W)) u_in_dly (
      .clk (clk), .rst (rst), .en (in_valid), .d (x_in[k]), .q (x_dly[k])
    );
    dly_line #(.DEPTH((NLANES - 1 - k) * D), .DATA_W(DATA_W)) u_out_dly (
      .clk (clk), .rst (rst), .en (in_valid), .d (sw[k]), .q (y_pre[k])
    );
  end

  // Rotating switch: the current segment selects which delayed lane feeds each output.
  always_comb begin
    for (int k = 0; k < NLANES; k++) sw[k] = x_dly[src_lane(seg_q, k)];
  end

  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    off_d    = off_q;
    seg_d    = seg_q;
    primed_d = primed_q;
    if (in_valid) begin
      if (off_q == OFF_LAST) begin
        off_d = '0;
        unique case (seg_q)
          SEG0:    seg_d = SEG1;
          SEG1:    seg_d = SEG2;
          default: seg_d = SEG0;
        endcase
        if (seg_q == SEG1) primed_d = 1'b1;
      end else begin
        off_d = off_q + OFF_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      off_q    <= '0;
      seg_q    <= SEG0;
      primed_q <= 1'b0;
      valid_q  <= 1'b0;
      fs_q     <= 1'b0;
      for (int k = 0; k < NLANES; k++) y_q[k] <= '0;
    end else begin
      off_q    <= off_d;
      seg_q    <= seg_d;
      primed_q <= primed_d;
      valid_q  <= in_valid & primed_q;
      // Emitted position lags the accepted one by 2D, so segment 2 here means s'=0.
      fs_q     <= in_valid & primed_q & (seg_q == SEG2) & (off_q == '0);
      if (in_valid) begin
        for (int k = 0; k < NLANES; k++) y_q[k] <= y_pre[k];
      end
    end
  end

  assign out_valid   = valid_q;
  assign frame_start = fs_q;
  assign y0          = y_q[0];
  assign y1          = y_q[1];
  assign y2          = y_q[2];

endmodule
